uart_bit_sequencer: RTL and testbench

//  Parametrised TX frame bit sequencer for the UART transmit engine.
//  - Counts bit times (btu strobes) while the transmit engine holds doit high.
//  - Frame length is configurable at runtime: data bits, parity, 1 or 2 stops.
//  - Decodes the current frame phase and emits a shift strobe for the TX shift register.
//  - Flags frame completion to the TX control FSM.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_bit_sequencer_if.sv | 44 ++++
 rtl/uart_frame_cfg.sv | 69 ++++++
 rtl/uart_bit_sequencer.sv | 132 +++++++++++++
 tb/tb_uart_bit_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit engine.
package uart_pkg;

  typedef enum logic [1:0] {
    PH_START  = 2'd0,
    PH_DATA   = 2'd1,
    PH_PARITY = 2'd2,
    PH_STOP   = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACTIVE   = 2'd1,
    S_COMPLETE = 2'd2
  } seq_state_t;

  localparam int unsigned UART_MIN_DATA_BITS = 5;
  localparam int unsigned UART_RST_DATA_BITS = 8;

  // Clamp a requested data field length into [UART_MIN_DATA_BITS, max_bits].
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input int unsigned max_bits);
    if (32'(req) < UART_MIN_DATA_BITS) return 4'(UART_MIN_DATA_BITS);
    if (32'(req) > max_bits) return 4'(max_bits);
    return req;
  endfunction

endpackage

// File: rtl/uart_bit_sequencer_if.sv
// Handshake/config/status bundle between the TX control FSM and the bit sequencer.
// UART_BITSEQ_PARITY_EN adds the tx_bit / parity_bit signals.
interface uart_bit_sequencer_if #(
  parameter int unsigned MAX_DATA_BITS = 8,
  parameter int unsigned CNT_W         = $clog2(MAX_DATA_BITS + 5)
);

  logic             doit;
  logic             btu;
  logic [3:0]       data_bits;
  logic             parity_en;
  logic             two_stop;
  logic [CNT_W-1:0] bit_cnt;
  logic [1:0]       phase;
  logic             shift;
  logic             busy;
  logic             done;
  logic             done_pulse;
`ifdef UART_BITSEQ_PARITY_EN
  logic             tx_bit;
  logic             parity_bit;

  modport master (
    output doit, btu, data_bits, parity_en, two_stop, tx_bit,
    input  bit_cnt, phase, shift, busy, done, done_pulse, parity_bit
  );

  modport slave (
    input  doit, btu, data_bits, parity_en, two_stop, tx_bit,
    output bit_cnt, phase, shift, busy, done, done_pulse, parity_bit
  );
`else
  modport master (
    output doit, btu, data_bits, parity_en, two_stop,
    input  bit_cnt, phase, shift, busy, done, done_pulse
  );

  modport slave (
    input  doit, btu, data_bits, parity_en, two_stop,
    output bit_cnt, phase, shift, busy, done, done_pulse
  );
`endif

endinterface

// File: rtl/uart_frame_cfg.sv
// Frame configuration latch: clamps data bits, holds parity/stop selection, derives flen.
// Parity is only honoured when UART_BITSEQ_PARITY_EN is defined.
module uart_frame_cfg
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DATA_BITS = 8,
  parameter int unsigned CNT_W         = $clog2(MAX_DATA_BITS + 5)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [3:0]       data_bits_i,
  input  logic             parity_en_i,
  input  logic             two_stop_i,
  output logic [3:0]       data_bits_o,
  output logic             parity_en_o,
  output logic [CNT_W-1:0] flen_o
);

  localparam int unsigned RstDataBits =
      (MAX_DATA_BITS < UART_RST_DATA_BITS) ? MAX_DATA_BITS : UART_RST_DATA_BITS;

  logic [3:0] data_bits_q, data_bits_d;
  logic       two_stop_q, two_stop_d;

  always_comb begin
    data_bits_d = data_bits_q;
    two_stop_d  = two_stop_q;
    if (load_i) begin
      data_bits_d = clamp_data_bits(data_bits_i, MAX_DATA_BITS);
      two_stop_d  = two_stop_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_bits_q <= 4'(RstDataBits);
      two_stop_q  <= 1'b0;
    end else begin
      data_bits_q <= data_bits_d;
      two_stop_q  <= two_stop_d;
    end
  end

`ifdef UART_BITSEQ_PARITY_EN
  logic parity_en_q, parity_en_d;

  always_comb begin
    parity_en_d = parity_en_q;
    if (load_i) parity_en_d = parity_en_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_en_q <= 1'b0;
    else       parity_en_q <= parity_en_d;
  end

  assign parity_en_o = parity_en_q;
`else
  logic unused_parity_en;
  assign unused_parity_en = parity_en_i;
  assign parity_en_o      = 1'b0;
`endif

  assign data_bits_o = data_bits_q;
  assign flen_o      = CNT_W'(1) + CNT_W'(data_bits_q) + CNT_W'(parity_en_o)
                     + (two_stop_q ? CNT_W'(2) : CNT_W'(1));

endmodule

// File: rtl/uart_bit_sequencer.sv
// TX frame bit sequencer: counts bit times, decodes frame phase, strobes the shift register.
// UART_BITSEQ_PARITY_EN enables the parity phase and the running parity_bit accumulator.
module uart_bit_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DATA_BITS = 8,
  parameter int unsigned CNT_W         = $clog2(MAX_DATA_BITS + 5)
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_bit_sequencer_if.slave  bus
);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             done_pulse_q, done_pulse_d;

  logic [3:0]       cfg_data_bits;
  logic             cfg_parity_en;
  logic [CNT_W-1:0] flen;
  logic [CNT_W-1:0] data_len;
  logic             frame_start;
  logic             shift;
  phase_t           phase_dec;

  assign frame_start = (state_q == S_IDLE) & bus.doit;
  assign data_len    = CNT_W'(cfg_data_bits);

  uart_frame_cfg #(
    .MAX_DATA_BITS (MAX_DATA_BITS),
    .CNT_W         (CNT_W)
  ) u_frame_cfg (
    .clk         (clk),
    .reset       (reset),
    .load_i      (frame_start),
    .data_bits_i (bus.data_bits),
    .parity_en_i (bus.parity_en),
    .two_stop_i  (bus.two_stop),
    .data_bits_o (cfg_data_bits),
    .parity_en_o (cfg_parity_en),
    .flen_o      (flen)
  );

  // Dropping doit aborts from any state, even if btu arrives in the same cycle.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    done_pulse_d = 1'b0;
    if (!bus.doit) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d   = S_ACTIVE;
          bit_cnt_d = '0;
        end
        S_ACTIVE: begin
          if (bus.btu) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == flen - CNT_W'(1)) begin
              state_d      = S_COMPLETE;
              done_pulse_d = 1'b1;
            end
          end
        end
        S_COMPLETE: begin
          state_d = S_COMPLETE;
        end
        default: begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  always_comb begin
    if (bit_cnt_q == '0) begin
      phase_dec = PH_START;
    end else if (bit_cnt_q <= data_len) begin
      phase_dec = PH_DATA;
    end else if (cfg_parity_en && (bit_cnt_q == data_len + CNT_W'(1))) begin
      phase_dec = PH_PARITY;
    end else begin
      phase_dec = PH_STOP;
    end
  end

  // cnt < D is the same as the next count landing in 1..D.
  assign shift = bus.doit & bus.btu & (state_q == S_ACTIVE) & (bit_cnt_q < data_len);

`ifdef UART_BITSEQ_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (frame_start) begin
      parity_d = 1'b0;
    end else if (shift) begin
      parity_d = parity_q ^ bus.tx_bit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  assign bus.parity_bit = parity_q;
`endif

  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.phase      = phase_dec;
  assign bus.shift      = shift;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_COMPLETE);
  assign bus.done_pulse = done_pulse_q;

endmodule

// File: tb/tb_uart_bit_sequencer.sv
// Scoreboard bench for uart_bit_sequencer: directed frames plus randomized frames vs. a
// frame-layout reference model. Honours UART_BITSEQ_PARITY_EN when defined.
module tb_uart_bit_sequencer;
  import uart_pkg::*;

  localparam int unsigned MaxDataBits = 8;
  localparam int unsigned CntW        = $clog2(MaxDataBits + 5);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_bit_sequencer_if #(.MAX_DATA_BITS(MaxDataBits)) bus ();

  uart_bit_sequencer #(.MAX_DATA_BITS(MaxDataBits)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int cnt;
    int ph;
    int sh;
    int busy;
    int done;
    int dp;
    int par;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   shift_seen = 0;

  // Reference model: frame described as a list of phases, one entry per bit time.
  int m_st;      // 0 idle, 1 counting, 2 complete
  int m_cnt;
  int m_d;
  int m_flen;
  int m_dp;
  int m_par;
  int m_layout[$];

  function automatic void check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void build_cfg(input int db, input bit pe, input bit ts);
    int p;
    int s;
    m_d = (db < 5) ? 5 : ((db > int'(MaxDataBits)) ? int'(MaxDataBits) : db);
`ifdef UART_BITSEQ_PARITY_EN
    p = pe ? 1 : 0;
`else
    p = 0;
`endif
    s = ts ? 2 : 1;
    m_flen = 1 + m_d + p + s;
    m_layout.delete();
    m_layout.push_back(0);
    for (int i = 0; i < m_d; i++) m_layout.push_back(1);
    for (int i = 0; i < p; i++) m_layout.push_back(2);
    for (int i = 0; i < s; i++) m_layout.push_back(3);
  endfunction

  function automatic void model_reset();
    m_st  = 0;
    m_cnt = 0;
    m_dp  = 0;
    m_par = 0;
    build_cfg(8, 1'b0, 1'b0);
  endfunction

  function automatic int phase_of(input int cnt);
    if (cnt < m_layout.size()) return m_layout[cnt];
    return 3;
  endfunction

  // One clock cycle of stimulus; expected outputs for this cycle go to the scoreboard.
  task automatic step(input bit rst, input bit doit, input bit btu, input int db,
                      input bit pe, input bit ts, input bit txb);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.doit      = doit;
    bus.btu       = btu;
    bus.data_bits = 4'(db);
    bus.parity_en = pe;
    bus.two_stop  = ts;
`ifdef UART_BITSEQ_PARITY_EN
    bus.tx_bit    = txb;
`endif
    if (rst) model_reset();
    e.cnt  = m_cnt;
    e.ph   = phase_of(m_cnt);
    e.sh   = (!rst && doit && btu && m_st == 1 && m_cnt < m_d) ? 1 : 0;
    e.busy = (m_st != 0) ? 1 : 0;
    e.done = (m_st == 2) ? 1 : 0;
    e.dp   = m_dp;
    e.par  = m_par;
    exp_q.push_back(e);
    if (rst) begin
      // stays in reset state
    end else if (!doit) begin
      m_st  = 0;
      m_cnt = 0;
      m_dp  = 0;
    end else if (m_st == 0) begin
      build_cfg(db, pe, ts);
      m_st  = 1;
      m_cnt = 0;
      m_par = 0;
      m_dp  = 0;
    end else if (m_st == 1 && btu) begin
      if (e.sh == 1) m_par = m_par ^ int'(txb);
      m_cnt++;
      m_dp = (m_cnt == m_flen) ? 1 : 0;
      if (m_dp == 1) m_st = 2;
    end else begin
      m_dp = 0;
    end
  endtask

  task automatic idle(input bit btu);
    step(1'b0, 1'b0, btu, 8, 1'b0, 1'b0, 1'b0);
  endtask

  // Start a frame, then issue nbtu strobes (optionally with gap cycles); doit stays high.
  task automatic run_frame(input int db, input bit pe, input bit ts, input int nbtu,
                           input int data, input bit gaps);
    int k;
    bit b;
    k = 0;
    step(1'b0, 1'b1, 1'b0, db, pe, ts, 1'b0);
    while (k < nbtu) begin
      b = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      step(1'b0, 1'b1, b, db, pe, ts, 1'((data >> k) & 1));
      if (b) k++;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("bit_cnt", int'(bus.bit_cnt), e.cnt);
      check("phase", int'(bus.phase), e.ph);
      check("shift", int'(bus.shift), e.sh);
      check("busy", int'(bus.busy), e.busy);
      check("done", int'(bus.done), e.done);
      check("done_pulse", int'(bus.done_pulse), e.dp);
`ifdef UART_BITSEQ_PARITY_EN
      check("parity_bit", int'(bus.parity_bit), e.par);
`endif
      if (bus.shift) shift_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int db;
    bit pe;
    bit ts;
    int nb;
    bit gp;
    bus.doit      = 1'b0;
    bus.btu       = 1'b0;
    bus.data_bits = 4'd8;
    bus.parity_en = 1'b0;
    bus.two_stop  = 1'b0;
`ifdef UART_BITSEQ_PARITY_EN
    bus.tx_bit    = 1'b0;
`endif
    model_reset();

    // Reset state, then 8N1 with back-to-back strobes.
    step(1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    shift_seen = 0;
    run_frame(8, 1'b0, 1'b0, 10, int'($urandom), 1'b0);
    step(1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("shift_count_8n1", shift_seen, 8);

    // 7E2 carrying 0x55.
    run_frame(7, 1'b1, 1'b1, 11, 32'h55, 1'b0);
    step(1'b0, 1'b1, 1'b0, 7, 1'b1, 1'b1, 1'b0);
    idle(1'b0);

    // Abort after 4 strobes, then restart from zero.
    run_frame(8, 1'b0, 1'b0, 4, int'($urandom), 1'b0);
    idle(1'b0);
    idle(1'b0);
    run_frame(8, 1'b0, 1'b0, 3, int'($urandom), 1'b1);
    idle(1'b1);

    // Extra strobes while complete.
    run_frame(8, 1'b0, 1'b0, 15, int'($urandom), 1'b1);
    idle(1'b0);
    idle(1'b0);

    // Clamping, and data_bits changes mid-frame.
    run_frame(3, 1'b0, 1'b0, 8, int'($urandom), 1'b0);
    idle(1'b0);
    step(1'b0, 1'b1, 1'b0, 15, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b1, 1'b1, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(1'b0);

    // Asynchronous reset at bit_cnt 6, clean restart on release.
    run_frame(8, 1'b0, 1'b0, 6, int'($urandom), 1'b0);
    step(1'b1, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b0);
    run_frame(8, 1'b0, 1'b0, 10, int'($urandom), 1'b0);
    step(1'b0, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b0);
    idle(1'b1);

    // Randomized frames: random config, strobe gaps, early aborts and overruns.
    for (int f = 0; f < 60; f++) begin
      db = int'($urandom_range(0, 15));
      pe = 1'($urandom_range(0, 1));
      ts = 1'($urandom_range(0, 1));
      nb = int'($urandom_range(1, 15));
      gp = 1'($urandom_range(0, 1));
      run_frame(db, pe, ts, nb, int'($urandom), gp);
      if ((f % 9) == 4) begin
        step(1'b1, 1'b1, 1'b1, db, pe, ts, 1'b0);
      end
      idle(1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
